// File: rtl/exu_pkg.sv
// Shared EXU definitions: fixed divide-sequence opcodes, flag bit positions
// and the divide sequencer state encoding.
package exu_pkg;

    localparam logic [15:0] OP_DIV0U = 16'h0019;
    localparam logic [15:0] OP_DIV0S = 16'h2127;
    localparam logic [15:0] OP_ROTCL = 16'h4024;
    localparam logic [15:0] OP_DIV1  = 16'h3124;

    // Flag vector layout is {M, Q, S, T}.
    localparam int unsigned FLG_M = 3;
    localparam int unsigned FLG_Q = 2;
    localparam int unsigned FLG_S = 1;
    localparam int unsigned FLG_T = 0;

    typedef enum logic [2:0] {IDLE, ROT, DIV, FIN, DONE} div_state_e;

endpackage

// File: rtl/exu_port_mux.sv
// Issue-port arbiter: the divide sequencer owns the EXU port whenever it is
// active or claiming the port for a start; otherwise pipeline ops pass through.
module exu_port_mux (
    input  logic        seq_sel,
    input  logic        pipe_valid,
    input  logic [15:0] pipe_raw,
    input  logic [31:0] pipe_opl,
    input  logic [31:0] pipe_oph,
    input  logic [3:0]  pipe_flags,
    input  logic        seq_valid,
    input  logic [15:0] seq_raw,
    input  logic [31:0] seq_opl,
    input  logic [31:0] seq_oph,
    input  logic [3:0]  seq_flags,
    output logic        pipe_ready,
    output logic        ex_valid,
    output logic [15:0] ex_raw,
    output logic [31:0] ex_opl,
    output logic [31:0] ex_oph,
    output logic [3:0]  ex_flags
);

    // Select the issue source; the pipeline is stalled while the sequencer owns the port.
    always_comb begin
        pipe_ready = ~seq_sel;
        if (seq_sel) begin
            ex_valid = seq_valid;
            ex_raw   = seq_raw;
            ex_opl   = seq_opl;
            ex_oph   = seq_oph;
            ex_flags = seq_flags;
        end else begin
            ex_valid = pipe_valid;
            ex_raw   = pipe_raw;
            ex_opl   = pipe_opl;
            ex_oph   = pipe_oph;
            ex_flags = pipe_flags;
        end
    end

endmodule

// File: rtl/exu_div_seq.sv
// 64/32 divide macro-sequencer sharing the EXU issue port with the pipeline.
// Drives DIV0x, then STEPS x (ROTCL lo; DIV1 dvs,hi), then a final ROTCL lo,
// and returns quotient, raw partial remainder and flags.
module exu_div_seq
    import exu_pkg::*;
#(
    parameter int unsigned STEPS = 32,
    parameter int unsigned CW    = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        pipe_valid,
    input  logic [15:0] pipe_raw,
    input  logic [31:0] pipe_opl,
    input  logic [31:0] pipe_oph,
    input  logic [3:0]  pipe_flags,
    output logic        pipe_ready,
    input  logic        div_start,
    input  logic        div_signed,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    input  logic [31:0] div_dvs,
    input  logic [3:0]  div_flags,
    output logic        div_busy,
    output logic        done_valid,
    output logic [31:0] done_quot,
    output logic [31:0] done_rem,
    output logic [3:0]  done_flags,
    output logic        ex_valid,
    output logic [15:0] ex_raw,
    output logic [31:0] ex_opl,
    output logic [31:0] ex_oph,
    output logic [3:0]  ex_flags,
    input  logic [3:0]  ex_out_flags,
    input  logic [31:0] ex_out_wdata
);

    localparam logic [CW-1:0] LastCnt = CW'(STEPS - 1);

    div_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d, dvs_q, dvs_d;
    logic [3:0]    flg_q, flg_d;
    logic          done_valid_q, done_valid_d;
    logic [31:0]   done_quot_q, done_quot_d, done_rem_q, done_rem_d;
    logic [3:0]    done_flags_q, done_flags_d;

    logic          start_go;
    logic          seq_sel;
    logic          seq_valid;
    logic [15:0]   seq_raw;
    logic [31:0]   seq_opl, seq_oph;
    logic [3:0]    seq_flags;

    // A flush in the start cycle cancels the start and leaves the port to the pipeline.
    assign start_go = (state_q == IDLE) && div_start && !flush;
    assign seq_sel  = (state_q != IDLE) || start_go;

    // Sequencer op for the current state; DIV0x uses the raw div_* inputs.
    always_comb begin
        seq_valid = 1'b1;
        seq_raw   = OP_ROTCL;
        seq_opl   = '0;
        seq_oph   = lo_q;
        seq_flags = flg_q;
        unique case (state_q)
            IDLE: begin
                seq_raw   = div_signed ? OP_DIV0S : OP_DIV0U;
                seq_opl   = div_dvs;
                seq_oph   = div_hi;
                seq_flags = div_flags;
            end
            ROT, FIN: ;
            DIV: begin
                seq_raw = OP_DIV1;
                seq_opl = dvs_q;
                seq_oph = hi_q;
            end
            DONE:    seq_valid = 1'b0;
            default: seq_valid = 1'b0;
        endcase
    end

    // Next-state and datapath update; EXU write data is routed by state.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        dvs_d        = dvs_q;
        flg_d        = flg_q;
        done_valid_d = 1'b0;
        done_quot_d  = done_quot_q;
        done_rem_d   = done_rem_q;
        done_flags_d = done_flags_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (div_start) begin
                        hi_d    = div_hi;
                        lo_d    = div_lo;
                        dvs_d   = div_dvs;
                        flg_d   = ex_out_flags;
                        cnt_d   = '0;
                        state_d = ROT;
                    end
                end
                ROT: begin
                    lo_d    = ex_out_wdata;
                    flg_d   = ex_out_flags;
                    state_d = DIV;
                end
                DIV: begin
                    hi_d  = ex_out_wdata;
                    flg_d = ex_out_flags;
                    if (cnt_q == LastCnt) begin
                        cnt_d   = '0;
                        state_d = FIN;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        state_d = ROT;
                    end
                end
                FIN: begin
                    lo_d         = ex_out_wdata;
                    flg_d        = ex_out_flags;
                    done_quot_d  = ex_out_wdata;
                    done_rem_d   = hi_q;
                    done_flags_d = ex_out_flags;
                    done_valid_d = 1'b1;
                    state_d      = DONE;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State, datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            dvs_q        <= '0;
            flg_q        <= '0;
            done_valid_q <= 1'b0;
            done_quot_q  <= '0;
            done_rem_q   <= '0;
            done_flags_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            dvs_q        <= dvs_d;
            flg_q        <= flg_d;
            done_valid_q <= done_valid_d;
            done_quot_q  <= done_quot_d;
            done_rem_q   <= done_rem_d;
            done_flags_q <= done_flags_d;
        end
    end

    // A flush during DONE still suppresses the result strobe.
    assign done_valid = done_valid_q & ~flush;
    assign done_quot  = done_quot_q;
    assign done_rem   = done_rem_q;
    assign done_flags = done_flags_q;
    assign div_busy   = (state_q != IDLE);

    exu_port_mux u_port_mux (
        .seq_sel    (seq_sel),
        .pipe_valid (pipe_valid),
        .pipe_raw   (pipe_raw),
        .pipe_opl   (pipe_opl),
        .pipe_oph   (pipe_oph),
        .pipe_flags (pipe_flags),
        .seq_valid  (seq_valid),
        .seq_raw    (seq_raw),
        .seq_opl    (seq_opl),
        .seq_oph    (seq_oph),
        .seq_flags  (seq_flags),
        .pipe_ready (pipe_ready),
        .ex_valid   (ex_valid),
        .ex_raw     (ex_raw),
        .ex_opl     (ex_opl),
        .ex_oph     (ex_oph),
        .ex_flags   (ex_flags)
    );

    cnt_in_range_a: assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= LastCnt);

endmodule

// File: tb/tb_exu_div_seq.sv
// Bench for exu_div_seq: a behavioural EXU model is attached to the issue port,
// results are scoreboarded against a reference built from the divide recipe
// and, for unsigned operands, from plain 64/32 division.
module tb_exu_div_seq;
    import exu_pkg::*;

    localparam int unsigned STEPS = 32;
    localparam int unsigned CW    = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        pipe_valid;
    logic [15:0] pipe_raw;
    logic [31:0] pipe_opl, pipe_oph;
    logic [3:0]  pipe_flags;
    logic        pipe_ready;
    logic        div_start, div_signed;
    logic [31:0] div_hi, div_lo, div_dvs;
    logic [3:0]  div_flags;
    logic        div_busy, done_valid;
    logic [31:0] done_quot, done_rem;
    logic [3:0]  done_flags;
    logic        ex_valid;
    logic [15:0] ex_raw;
    logic [31:0] ex_opl, ex_oph;
    logic [3:0]  ex_flags;
    logic [3:0]  ex_out_flags;
    logic [31:0] ex_out_wdata;

    typedef struct packed { logic [31:0] w; logic [3:0] f; } exu_res_t;
    typedef struct { logic [31:0] quot; logic [31:0] rem; logic [3:0] flags; logic [3:0] flg0; } ref_t;
    typedef struct { logic [31:0] quot; logic [31:0] rem; logic [3:0] flags; int due; } exp_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t sb[$];
    exp_t me;
    exu_res_t xr;

    exu_div_seq #(.STEPS(STEPS), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .pipe_valid(pipe_valid), .pipe_raw(pipe_raw), .pipe_opl(pipe_opl),
        .pipe_oph(pipe_oph), .pipe_flags(pipe_flags), .pipe_ready(pipe_ready),
        .div_start(div_start), .div_signed(div_signed), .div_hi(div_hi),
        .div_lo(div_lo), .div_dvs(div_dvs), .div_flags(div_flags),
        .div_busy(div_busy), .done_valid(done_valid), .done_quot(done_quot),
        .done_rem(done_rem), .done_flags(done_flags),
        .ex_valid(ex_valid), .ex_raw(ex_raw), .ex_opl(ex_opl), .ex_oph(ex_oph),
        .ex_flags(ex_flags), .ex_out_flags(ex_out_flags), .ex_out_wdata(ex_out_wdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SH-style EXU: DIV0U/DIV0S/ROTCL/DIV1, anything else adds.
    function automatic exu_res_t exu_eval(input logic [15:0] raw, input logic [31:0] opl,
                                          input logic [31:0] oph, input logic [3:0] fin);
        exu_res_t    r;
        logic [31:0] rn;
        logic [32:0] s;
        logic        q;
        r.w = opl + oph;
        r.f = fin;
        if (raw == OP_DIV0U) begin
            r.f[FLG_M] = 1'b0;
            r.f[FLG_Q] = 1'b0;
            r.f[FLG_T] = 1'b0;
        end else if (raw == OP_DIV0S) begin
            r.f[FLG_M] = opl[31];
            r.f[FLG_Q] = oph[31];
            r.f[FLG_T] = opl[31] ^ oph[31];
        end else if (raw == OP_ROTCL) begin
            r.w        = {oph[30:0], fin[FLG_T]};
            r.f[FLG_T] = oph[31];
        end else if (raw == OP_DIV1) begin
            q  = oph[31];
            rn = {oph[30:0], fin[FLG_T]};
            if (fin[FLG_Q] == fin[FLG_M]) s = {1'b0, rn} - {1'b0, opl};
            else                          s = {1'b0, rn} + {1'b0, opl};
            r.w        = s[31:0];
            r.f[FLG_Q] = q ^ s[32] ^ fin[FLG_M];
            r.f[FLG_T] = (r.f[FLG_Q] == fin[FLG_M]);
        end
        return r;
    endfunction

    always_comb begin
        xr           = exu_eval(ex_raw, ex_opl, ex_oph, ex_flags);
        ex_out_wdata = xr.w;
        ex_out_flags = xr.f;
    end

    // Reference: the divide recipe expanded as a plain loop of EXU operations.
    function automatic ref_t run_ref(input logic sgn, input logic [31:0] hi, input logic [31:0] lo,
                                     input logic [31:0] dvs, input logic [3:0] fl);
        ref_t     o;
        exu_res_t r;
        logic [3:0] f;
        r = exu_eval(sgn ? OP_DIV0S : OP_DIV0U, dvs, hi, fl);
        f = r.f;
        o.flg0 = f;
        for (int i = 0; i < int'(STEPS); i++) begin
            r = exu_eval(OP_ROTCL, 32'h0, lo, f);
            lo = r.w; f = r.f;
            r = exu_eval(OP_DIV1, dvs, hi, f);
            hi = r.w; f = r.f;
        end
        r = exu_eval(OP_ROTCL, 32'h0, lo, f);
        o.quot  = r.w;
        o.flags = r.f;
        o.rem   = hi;
        return o;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every result strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done_valid) begin
            if (sb.size() == 0) begin
                chk("done_unexpected", {63'd0, done_valid}, 64'd0);
            end else begin
                me = sb.pop_front();
                chk("done_quot", {32'd0, done_quot}, {32'd0, me.quot});
                chk("done_rem", {32'd0, done_rem}, {32'd0, me.rem});
                chk("done_flags", {60'd0, done_flags}, {60'd0, me.flags});
                chk("done_cycle", 64'(cyc), 64'(me.due));
            end
        end
    end

    // Runs one full divide; called and returns at posedge+1.
    task automatic do_div(input logic sgn, input logic [31:0] hi, input logic [31:0] lo,
                          input logic [31:0] dvs, input logic [3:0] fl, input logic pv);
        ref_t        r;
        exp_t        e;
        logic [63:0] q64;
        logic [15:0] exp_raw;
        bit          bad_stall, bad_ops, got;
        r = run_ref(sgn, hi, lo, dvs, fl);
        div_start = 1'b1; div_signed = sgn; div_hi = hi; div_lo = lo; div_dvs = dvs;
        div_flags = fl;
        pipe_valid = pv; pipe_raw = 16'h312C; pipe_opl = $urandom; pipe_oph = $urandom;
        pipe_flags = 4'($urandom);
        @(negedge clk);
        chk("start_raw", {48'd0, ex_raw}, {48'd0, (sgn ? OP_DIV0S : OP_DIV0U)});
        chk("start_ready", {63'd0, pipe_ready}, 64'd0);
        chk("start_flags", {60'd0, ex_flags}, {60'd0, fl});
        q64    = {hi, lo} / {32'd0, dvs};
        e.quot = (!sgn && hi < dvs) ? q64[31:0] : r.quot;
        e.rem  = r.rem;
        e.flags = r.flags;
        e.due  = cyc + 2 * int'(STEPS) + 2;
        sb.push_back(e);
        @(posedge clk); #1;
        div_start = 1'b0; div_signed = 1'($urandom); div_hi = $urandom; div_lo = $urandom;
        div_dvs = $urandom; div_flags = 4'($urandom);
        @(negedge clk);
        chk("setup_flags", {60'd0, ex_flags}, {60'd0, r.flg0});
        bad_stall = 0; bad_ops = 0; got = 0;
        for (int k = 1; k <= 2 * int'(STEPS) + 6; k++) begin
            if (k > 1) @(negedge clk);
            if (done_valid) begin
                got = 1;
                if (ex_valid !== 1'b0 || div_busy !== 1'b1 || pipe_ready !== 1'b0) bad_stall = 1;
                break;
            end
            exp_raw = (k % 2 == 1) ? OP_ROTCL : OP_DIV1;
            if (ex_raw !== exp_raw || ex_valid !== 1'b1) bad_ops = 1;
            if (div_busy !== 1'b1 || pipe_ready !== 1'b0) bad_stall = 1;
        end
        chk("done_seen", {63'd0, got}, 64'd1);
        chk("stall_ok", {63'd0, bad_stall}, 64'd0);
        chk("seq_ops", {63'd0, bad_ops}, 64'd0);
        @(negedge clk);
        chk("ready_after", {63'd0, pipe_ready}, 64'd1);
        chk("busy_after", {63'd0, div_busy}, 64'd0);
        chk("pipe_after_valid", {63'd0, ex_valid}, {63'd0, pv});
        chk("pipe_after_raw", {48'd0, ex_raw}, 64'h312C);
        @(posedge clk); #1;
        pipe_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, h;
        bit          seen;
        rst_n = 1'b0; flush = 1'b0;
        pipe_valid = 1'b0; pipe_raw = '0; pipe_opl = '0; pipe_oph = '0; pipe_flags = '0;
        div_start = 1'b0; div_signed = 1'b0; div_hi = '0; div_lo = '0; div_dvs = '0;
        div_flags = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {63'd0, div_busy}, 64'd0);
        chk("rst_done_valid", {63'd0, done_valid}, 64'd0);
        chk("rst_done_quot", {32'd0, done_quot}, 64'd0);
        chk("rst_done_rem", {32'd0, done_rem}, 64'd0);
        chk("rst_done_flags", {60'd0, done_flags}, 64'd0);
        chk("rst_ready", {63'd0, pipe_ready}, 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Passthrough of an ordinary pipeline op.
        pipe_valid = 1'b1; pipe_raw = 16'h312C; pipe_opl = 32'd5; pipe_oph = 32'd7;
        pipe_flags = 4'h2;
        @(negedge clk);
        chk("pt_valid", {63'd0, ex_valid}, 64'd1);
        chk("pt_raw", {48'd0, ex_raw}, 64'h312C);
        chk("pt_opl", {32'd0, ex_opl}, 64'd5);
        chk("pt_oph", {32'd0, ex_oph}, 64'd7);
        chk("pt_flags", {60'd0, ex_flags}, 64'h2);
        chk("pt_ready", {63'd0, pipe_ready}, 64'd1);
        chk("pt_busy", {63'd0, div_busy}, 64'd0);
        @(posedge clk); #1;
        pipe_valid = 1'b0;

        // 100/7 unsigned, colliding with a pipeline op in the start cycle.
        do_div(1'b0, 32'd0, 32'd100, 32'd7, 4'h0, 1'b1);
        // Signed setup with a negative divisor.
        do_div(1'b1, 32'd0, 32'd100, 32'hFFFF_FFF9, 4'h0, 1'b0);

        // Random unsigned divides with hi < dvs, including the largest divisor.
        for (int i = 0; i < 8; i++) begin
            d = (i == 0) ? 32'hFFFF_FFFF : (($urandom % 2) ? $urandom : ($urandom_range(1, 255)));
            if (d == 0) d = 1;
            h = $urandom % d;
            do_div(1'b0, h, $urandom, d, 4'($urandom), 1'($urandom));
        end
        // Random signed divides (raw sequence result).
        for (int i = 0; i < 4; i++)
            do_div(1'b1, $urandom, $urandom, $urandom, 4'($urandom), 1'($urandom));

        // Flush in the start cycle cancels the start; passthrough continues.
        div_start = 1'b1; flush = 1'b1; div_hi = 0; div_lo = 100; div_dvs = 7;
        pipe_valid = 1'b1; pipe_raw = 16'h312C;
        @(negedge clk);
        chk("fl0_ready", {63'd0, pipe_ready}, 64'd1);
        chk("fl0_raw", {48'd0, ex_raw}, 64'h312C);
        @(posedge clk); #1;
        div_start = 1'b0; flush = 1'b0; pipe_valid = 1'b0;
        @(negedge clk);
        chk("fl0_busy", {63'd0, div_busy}, 64'd0);

        // Flush at cycle 20 of a divide.
        @(posedge clk); #1;
        div_start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            div_start = 1'b0;
        end
        flush = 1'b1;
        @(negedge clk);
        chk("fl20_busy_before", {63'd0, div_busy}, 64'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("fl20_busy", {63'd0, div_busy}, 64'd0);
        chk("fl20_ready", {63'd0, pipe_ready}, 64'd1);
        seen = 0;
        for (int i = 0; i < 2 * int'(STEPS) + 6; i++) begin
            @(negedge clk);
            if (done_valid) seen = 1;
        end
        chk("fl20_no_done", {63'd0, seen}, 64'd0);

        // Asynchronous reset at cycle 30 of a divide, then a fresh divide.
        @(posedge clk); #1;
        div_start = 1'b1; div_hi = 0; div_lo = 100; div_dvs = 7; div_signed = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            div_start = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", {63'd0, div_busy}, 64'd0);
        chk("mrst_done_valid", {63'd0, done_valid}, 64'd0);
        chk("mrst_done_quot", {32'd0, done_quot}, 64'd0);
        chk("mrst_done_flags", {60'd0, done_flags}, 64'd0);
        chk("mrst_ready", {63'd0, pipe_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_div(1'b0, 32'd0, 32'd100, 32'd7, 4'h0, 1'b0);

        repeat (4) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
